conv_stream_feeder: RTL and testbench

- Responder for the CONV engine's input side: answers CONV's `ifm_read`/`wgt_read` strobes with the next IFM pixel and weight word.
- Reads both from on-chip synchronous-read SRAMs.
- Issues the `start_conv` pulse to CONV, tracks `end_conv`, and reports busy/done/overrun to the layer sequencer.

---
 rtl/conv_stream_feeder_if.sv | 30 +++
 rtl/conv_stream_feeder.sv | 188 ++++++++++++++++++
 tb/tb_conv_stream_feeder.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/conv_stream_feeder_if.sv
// rtl/conv_stream_feeder_if.sv - CONV engine input-side handshake bundle (launch, completion, read strobes, data words)
interface conv_stream_feeder_if #(
    parameter int IFM_WIDTH    = 16,
    parameter int WEIGHT_WIDTH = 16
);
    logic                    start_conv;
    logic                    end_conv;
    logic                    ifm_read;
    logic                    wgt_read;
    logic [IFM_WIDTH-1:0]    ifm;
    logic [WEIGHT_WIDTH-1:0] wgt;

    modport master (
        output start_conv,
        output ifm,
        output wgt,
        input  end_conv,
        input  ifm_read,
        input  wgt_read
    );

    modport slave (
        input  start_conv,
        input  ifm,
        input  wgt,
        output end_conv,
        output ifm_read,
        output wgt_read
    );
endinterface

// File: rtl/conv_stream_feeder.sv
// rtl/conv_stream_feeder.sv - IFM/weight SRAM feeder for the CONV engine; CONV_FEEDER_ZERO_PAD_EN adds synthesized zero borders
module conv_stream_feeder #(
    parameter int IFM_WIDTH      = 16,
    parameter int WEIGHT_WIDTH   = 16,
    parameter int IFM_SIZE       = 64,
    parameter int KERNEL_SIZE    = 5,
    parameter int PAD            = 2,
    parameter int CI             = 3,
    parameter int CO             = 8,
    parameter int IFM_ADDR_WIDTH = $clog2(CI*IFM_SIZE*IFM_SIZE),
    parameter int WGT_ADDR_WIDTH = $clog2(CO*CI*KERNEL_SIZE*KERNEL_SIZE)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    output logic                      busy,
    output logic                      done,
    output logic                      overrun,
    conv_stream_feeder_if.master      conv,
    output logic                      ifm_mem_rd,
    output logic [IFM_ADDR_WIDTH-1:0] ifm_mem_addr,
    input  logic [IFM_WIDTH-1:0]      ifm_mem_rdata,
    output logic                      wgt_mem_rd,
    output logic [WGT_ADDR_WIDTH-1:0] wgt_mem_addr,
    input  logic [WEIGHT_WIDTH-1:0]   wgt_mem_rdata
);
`ifdef CONV_FEEDER_ZERO_PAD_EN
    localparam bit ZERO_PAD = 1'b1;
`else
    localparam bit ZERO_PAD = 1'b0;
`endif
    localparam int PAD_EFF   = ZERO_PAD ? PAD : 0;
    localparam int DIM       = IFM_SIZE + 2*PAD_EFF;
    localparam int PLANE     = IFM_SIZE*IFM_SIZE;
    localparam int WGT_TOTAL = CO*CI*KERNEL_SIZE*KERNEL_SIZE;
    localparam int POS_W     = (DIM > 1) ? $clog2(DIM) : 1;
    localparam int CI_W      = (CI > 1) ? $clog2(CI) : 1;
    localparam int CO_W      = (CO > 1) ? $clog2(CO) : 1;

    typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_RUN} state_t;

    state_t state, state_next;
    logic   start_acc;
    logic   in_run;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next      = state;
        busy            = 1'b0;
        done            = 1'b0;
        conv.start_conv = 1'b0;
        start_acc       = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    start_acc  = 1'b1;
                    state_next = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                busy            = 1'b1;
                conv.start_conv = 1'b1;
                state_next      = S_RUN;
            end
            S_RUN: begin
                busy = 1'b1;
                if (conv.end_conv) begin
                    done       = 1'b1;
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign in_run = (state == S_RUN);

    // IFM position counters walk the (padded) image: col fastest, then row, ci, co.
    logic [POS_W-1:0]     col, row;
    logic [CI_W-1:0]      ci;
    logic [CO_W-1:0]      co;
    logic                 ifm_exh, ifm_acc, ifm_last, ifm_border;
    logic                 ifm_pend, ifm_pend_zero;
    logic [IFM_WIDTH-1:0] ifm_q;

    assign ifm_last = (col == POS_W'(DIM-1)) && (row == POS_W'(DIM-1)) &&
                      (ci == CI_W'(CI-1)) && (co == CO_W'(CO-1));
    assign ifm_acc  = in_run && conv.ifm_read && !ifm_exh;

`ifdef CONV_FEEDER_ZERO_PAD_EN
    assign ifm_border = (32'(row) < PAD_EFF) || (32'(row) >= PAD_EFF + IFM_SIZE) ||
                        (32'(col) < PAD_EFF) || (32'(col) >= PAD_EFF + IFM_SIZE);
`else
    assign ifm_border = 1'b0;
`endif

    assign ifm_mem_rd   = ifm_acc && !ifm_border;
    assign ifm_mem_addr = IFM_ADDR_WIDTH'(32'(ci)*PLANE + (32'(row) - PAD_EFF)*IFM_SIZE
                                          + 32'(col) - PAD_EFF);
    assign conv.ifm     = ifm_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col           <= '0;
            row           <= '0;
            ci            <= '0;
            co            <= '0;
            ifm_exh       <= 1'b0;
            ifm_pend      <= 1'b0;
            ifm_pend_zero <= 1'b0;
            ifm_q         <= '0;
        end else begin
            ifm_pend      <= ifm_acc;
            ifm_pend_zero <= ifm_border;
            // Border words travel the same two-stage path so latency is position independent.
            if (ifm_pend) ifm_q <= ifm_pend_zero ? '0 : ifm_mem_rdata;
            if (start_acc) begin
                col     <= '0;
                row     <= '0;
                ci      <= '0;
                co      <= '0;
                ifm_exh <= 1'b0;
            end else if (ifm_acc) begin
                if (ifm_last) begin
                    ifm_exh <= 1'b1;
                end else if (col != POS_W'(DIM-1)) begin
                    col <= col + 1'b1;
                end else begin
                    col <= '0;
                    if (row != POS_W'(DIM-1)) begin
                        row <= row + 1'b1;
                    end else begin
                        row <= '0;
                        if (ci != CI_W'(CI-1)) begin
                            ci <= ci + 1'b1;
                        end else begin
                            ci <= '0;
                            co <= co + 1'b1;
                        end
                    end
                end
            end
        end
    end

    logic [WGT_ADDR_WIDTH-1:0] wgt_cnt;
    logic                      wgt_exh, wgt_acc, wgt_last, wgt_pend;
    logic [WEIGHT_WIDTH-1:0]   wgt_q;

    assign wgt_last     = (wgt_cnt == WGT_ADDR_WIDTH'(WGT_TOTAL-1));
    assign wgt_acc      = in_run && conv.wgt_read && !wgt_exh;
    assign wgt_mem_rd   = wgt_acc;
    assign wgt_mem_addr = wgt_cnt;
    assign conv.wgt     = wgt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wgt_cnt  <= '0;
            wgt_exh  <= 1'b0;
            wgt_pend <= 1'b0;
            wgt_q    <= '0;
        end else begin
            wgt_pend <= wgt_acc;
            if (wgt_pend) wgt_q <= wgt_mem_rdata;
            if (start_acc) begin
                wgt_cnt <= '0;
                wgt_exh <= 1'b0;
            end else if (wgt_acc) begin
                if (wgt_last) wgt_exh <= 1'b1;
                else          wgt_cnt <= wgt_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun <= 1'b0;
        end else if (start_acc) begin
            overrun <= 1'b0;
        end else if (in_run && ((conv.ifm_read && ifm_exh) || (conv.wgt_read && wgt_exh))) begin
            overrun <= 1'b1;
        end
    end
endmodule

// File: tb/tb_conv_stream_feeder.sv
// tb/tb_conv_stream_feeder.sv - directed bench for conv_stream_feeder (IFM 4x4, K 3, CI 2, CO 2, PAD 1)
module tb_conv_stream_feeder;
    localparam int IFM_SIZE = 4;
    localparam int KSZ      = 3;
    localparam int PAD      = 1;
    localparam int CI       = 2;
    localparam int CO       = 2;
`ifdef CONV_FEEDER_ZERO_PAD_EN
    localparam int PADX = PAD;
`else
    localparam int PADX = 0;
`endif
    localparam int P       = IFM_SIZE + 2*PADX;
    localparam int TOTAL_I = CO*CI*P*P;
    localparam int TOTAL_W = CO*CI*KSZ*KSZ;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        busy, done, overrun;
    logic        ifm_mem_rd, wgt_mem_rd;
    logic [4:0]  ifm_mem_addr;
    logic [5:0]  wgt_mem_addr;
    logic [15:0] ifm_mem_rdata = '0;
    logic [15:0] wgt_mem_rdata = '0;

    conv_stream_feeder_if #(.IFM_WIDTH(16), .WEIGHT_WIDTH(16)) cif ();

    conv_stream_feeder #(
        .IFM_WIDTH(16), .WEIGHT_WIDTH(16), .IFM_SIZE(IFM_SIZE), .KERNEL_SIZE(KSZ),
        .PAD(PAD), .CI(CI), .CO(CO), .IFM_ADDR_WIDTH(5), .WGT_ADDR_WIDTH(6)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .overrun(overrun),
        .conv(cif),
        .ifm_mem_rd(ifm_mem_rd), .ifm_mem_addr(ifm_mem_addr), .ifm_mem_rdata(ifm_mem_rdata),
        .wgt_mem_rd(wgt_mem_rd), .wgt_mem_addr(wgt_mem_addr), .wgt_mem_rdata(wgt_mem_rdata)
    );

    always #5 clk = ~clk;

    // Synchronous-read SRAMs: IFM[a] = a+100, WGT[a] = 1000+3a
    always @(posedge clk) begin
        if (ifm_mem_rd) ifm_mem_rdata <= 16'(100 + 32'(ifm_mem_addr));
        if (wgt_mem_rd) wgt_mem_rdata <= 16'(1000 + 3*32'(wgt_mem_addr));
    end

    int checks = 0;
    int failures = 0;

    int          m_state;
    int          ei, ew, rd_seen;
    bit          exp_ov;
    logic [15:0] exp_ifm, exp_wgt;
    bit          is1v, is2v, ws1v, ws2v;
    logic [15:0] is1, is2, ws1, ws2;
    logic [15:0] obs [10];

    typedef struct {
        bit ir; bit wr;
        bit e_ird; int e_iaddr;
        bit e_wrd; int e_waddr;
        int e_ifm; int e_wgt;
    } vec_t;
    vec_t tbl [7];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, got, want, $time);
        end
    endtask

    function automatic void ifm_pos(input int d, output bit rd, output int addr);
        int p, c_i, rc, r, c;
        p   = d % (CI*P*P);
        c_i = p / (P*P);
        rc  = p % (P*P);
        r   = rc / P;
        c   = rc % P;
`ifdef CONV_FEEDER_ZERO_PAD_EN
        rd = (r >= PAD) && (r < PAD + IFM_SIZE) && (c >= PAD) && (c < PAD + IFM_SIZE);
`else
        rd = 1'b1;
`endif
        addr = rd ? c_i*IFM_SIZE*IFM_SIZE + (r - PADX)*IFM_SIZE + (c - PADX) : 0;
    endfunction

    task automatic model_reset();
        m_state = 0; ei = 0; ew = 0; exp_ov = 0;
        exp_ifm = '0; exp_wgt = '0;
        is1v = 0; is2v = 0; ws1v = 0; ws2v = 0;
        is1 = '0; is2 = '0; ws1 = '0; ws2 = '0;
    endtask

    // One clock cycle: drive inputs mid-cycle, compare against the reference model, then advance it.
    task automatic step(input bit ir, input bit wr, input bit st, input bit ec);
        bit i_acc, w_acc, pos_rd;
        int pos_addr;
        @(negedge clk);
        start = st; cif.ifm_read = ir; cif.wgt_read = wr; cif.end_conv = ec;
        #1;
        if (is2v) exp_ifm = is2;
        if (ws2v) exp_wgt = ws2;
        i_acc = (m_state == 2) && ir && (ei < TOTAL_I);
        w_acc = (m_state == 2) && wr && (ew < TOTAL_W);
        pos_rd = 0; pos_addr = 0;
        if (i_acc) ifm_pos(ei, pos_rd, pos_addr);
        chk("ifm_mem_rd", 32'(ifm_mem_rd), 32'(i_acc && pos_rd));
        if (i_acc && pos_rd) chk("ifm_mem_addr", 32'(ifm_mem_addr), pos_addr);
        chk("wgt_mem_rd", 32'(wgt_mem_rd), 32'(w_acc));
        if (w_acc) chk("wgt_mem_addr", 32'(wgt_mem_addr), ew);
        chk("ifm", 32'(cif.ifm), 32'(exp_ifm));
        chk("wgt", 32'(cif.wgt), 32'(exp_wgt));
        chk("start_conv", 32'(cif.start_conv), 32'(m_state == 1));
        chk("busy", 32'(busy), 32'(m_state != 0));
        chk("done", 32'(done), 32'(m_state == 2 && ec));
        chk("overrun", 32'(overrun), 32'(exp_ov));
        if (ifm_mem_rd) rd_seen++;
        is2v = is1v; is2 = is1; is1v = i_acc; is1 = pos_rd ? 16'(100 + pos_addr) : 16'd0;
        ws2v = ws1v; ws2 = ws1; ws1v = w_acc; ws1 = 16'(1000 + 3*ew);
        if (m_state == 2 && ((ir && ei >= TOTAL_I) || (wr && ew >= TOTAL_W))) exp_ov = 1;
        if (i_acc) ei++;
        if (w_acc) ew++;
        case (m_state)
            0: if (st) begin m_state = 1; ei = 0; ew = 0; exp_ov = 0; end
            1: m_state = 2;
            default: if (ec) m_state = 0;
        endcase
    endtask

    initial begin
        //         ir wr ird ia wrd wa  ifm  wgt
        tbl[0] = '{1, 1, 1, 0, 1, 0, 131, 1105};
        tbl[1] = '{0, 1, 0, 0, 1, 1, 131, 1105};
        tbl[2] = '{1, 0, 1, 1, 0, 0, 100, 1000};
        tbl[3] = '{1, 1, 1, 2, 1, 2, 100, 1003};
        tbl[4] = '{0, 0, 0, 0, 0, 0, 101, 1003};
        tbl[5] = '{0, 0, 0, 0, 0, 0, 102, 1006};
        tbl[6] = '{0, 0, 0, 0, 0, 0, 102, 1006};

        rst_n = 1'b0; start = 1'b0;
        cif.ifm_read = 1'b0; cif.wgt_read = 1'b0; cif.end_conv = 1'b0;
        model_reset();
        rd_seen = 0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_overrun", 32'(overrun), 0);
        chk("rst_start_conv", 32'(cif.start_conv), 0);
        chk("rst_ifm", 32'(cif.ifm), 0);
        chk("rst_wgt", 32'(cif.wgt), 0);
        chk("rst_ifm_rd", 32'(ifm_mem_rd), 0);
        chk("rst_wgt_rd", 32'(wgt_mem_rd), 0);
        @(negedge clk) rst_n = 1'b1;

        // Launch, then weights with random gaps
        step(0, 0, 1, 0);
        step(0, 0, 0, 0);
        for (int k = 0; k < TOTAL_W; k++) begin
            int gap;
            gap = $urandom_range(0, 2);
            repeat (gap) step(0, 0, 0, 0);
            step(0, 1, 0, 0);
        end
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("wgt_last_word", 32'(cif.wgt), 1105);
        chk("wgt_no_overrun", 32'(overrun), 0);

        // Full IFM stream with ifm_read held high
        rd_seen = 0;
        for (int i = 0; i < TOTAL_I; i++) begin
            step(1, 0, 0, 0);
            if (i < 10) obs[i] = cif.ifm;
`ifdef CONV_FEEDER_ZERO_PAD_EN
            if (i == P*P - 1) chk("pad_reads_per_channel", rd_seen, IFM_SIZE*IFM_SIZE);
`endif
        end
`ifdef CONV_FEEDER_ZERO_PAD_EN
        for (int i = 2; i < 9; i++) chk("pad_border_zero", 32'(obs[i]), 0);
        chk("pad_first_interior", 32'(obs[9]), 100);
`else
        chk("ifm_first_word", 32'(obs[2]), 100);
        chk("ifm_second_word", 32'(obs[3]), 101);
`endif

        // One strobe past the end
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
`ifndef CONV_FEEDER_ZERO_PAD_EN
        chk("ifm_hold_after_exhaust", 32'(cif.ifm), 131);
`endif
        chk("overrun_sticky", 32'(overrun), 1);

        // Completion, then a new start clears overrun
        step(0, 0, 0, 1);
        step(0, 0, 0, 0);
        step(0, 0, 1, 0);
        step(0, 0, 0, 0);

`ifndef CONV_FEEDER_ZERO_PAD_EN
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            cif.ifm_read = tbl[i].ir; cif.wgt_read = tbl[i].wr;
            #1;
            chk("tbl_ifm_rd", 32'(ifm_mem_rd), 32'(tbl[i].e_ird));
            if (tbl[i].e_ird) chk("tbl_ifm_addr", 32'(ifm_mem_addr), tbl[i].e_iaddr);
            chk("tbl_wgt_rd", 32'(wgt_mem_rd), 32'(tbl[i].e_wrd));
            if (tbl[i].e_wrd) chk("tbl_wgt_addr", 32'(wgt_mem_addr), tbl[i].e_waddr);
            chk("tbl_ifm", 32'(cif.ifm), tbl[i].e_ifm);
            chk("tbl_wgt", 32'(cif.wgt), tbl[i].e_wgt);
        end
`else
        for (int i = 0; i < 9; i++) step(1, 1, 0, 0);
`endif

        // Reset in the middle of a stream with a read in flight
        @(negedge clk);
        cif.ifm_read = 1'b1; cif.wgt_read = 1'b1;
        @(negedge clk);
        cif.ifm_read = 1'b0; cif.wgt_read = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_overrun", 32'(overrun), 0);
        chk("midrst_ifm", 32'(cif.ifm), 0);
        chk("midrst_wgt", 32'(cif.wgt), 0);
        chk("midrst_ifm_rd", 32'(ifm_mem_rd), 0);
        chk("midrst_start_conv", 32'(cif.start_conv), 0);
        model_reset();
        @(negedge clk) rst_n = 1'b1;

        // Strobes and end_conv outside RUN are ignored
        step(1, 1, 0, 0);
        step(1, 1, 0, 0);
        step(0, 0, 0, 1);

        // Restart from address 0, ignore start while busy, then complete
        step(0, 0, 1, 0);
        step(0, 0, 0, 0);
        step(1, 1, 0, 0);
        step(1, 0, 1, 0);
        step(0, 1, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 1);
        step(0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
